// File: rtl/patch_trigger_ctrl.sv
// patch_trigger_ctrl: trigger/override controller for one datapath patch point.
//
// It compares the observe bits against a programmed value/mask. After a match
// it waits a programmed delay. It then replaces the masked bits of the
// controlled signal for a programmed duration. When the override ends it
// either re-arms or parks in DONE (oneshot).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   observe_in        observe bits from the patch point
//   ctrl_in/ctrl_out  original control value in, (possibly patched) value out
//   cfg_we/addr/wdata configuration write port (8 registers, 8 bits each)
//   cfg_rdata         combinational read of the register at cfg_addr
//   patch_active      high while the override is applied
//   patch_done        high in DONE
module patch_trigger_ctrl #(
  parameter int OBS_W = 1,
  parameter int CTL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OBS_W-1:0] observe_in,
  input  logic [CTL_W-1:0] ctrl_in,
  output logic [CTL_W-1:0] ctrl_out,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  output logic             patch_active,
  output logic             patch_done
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_DELAY    = 3'd2,
    ST_OVERRIDE = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [7:0]       cnt_r, cnt_nxt_s;
  logic             enable_r, oneshot_r;
  logic [OBS_W-1:0] match_val_r, match_mask_r;
  logic [7:0]       delay_r, duration_r;
  logic [CTL_W-1:0] ovr_val_r, ovr_mask_r;
  logic [7:0]       hit_cnt_r;

  logic ctrl_wr_s, dis_wr_s, en_wr_s, hit_clr_s, match_s, fire_s, active_s;

  // Decode configuration strobes and the trigger match.
  always_comb begin
    ctrl_wr_s = cfg_we && (cfg_addr == 3'd0);
    dis_wr_s  = ctrl_wr_s && !cfg_wdata[0];
    en_wr_s   = ctrl_wr_s && cfg_wdata[0];
    hit_clr_s = cfg_we && (cfg_addr == 3'd7);
    match_s   = (((observe_in ^ match_val_r) & match_mask_r) == {OBS_W{1'b0}});
  end

  // State and counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; a disable write overrides every other event.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    fire_s      = 1'b0;
    if (dis_wr_s) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (en_wr_s) begin
            state_nxt_s = ST_ARMED;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (match_s) begin
            if (delay_r == 8'd0) begin
              state_nxt_s = ST_OVERRIDE;
              cnt_nxt_s   = duration_r - 8'd1;
              fire_s      = 1'b1;
            end else begin
              state_nxt_s = ST_DELAY;
              cnt_nxt_s   = delay_r - 8'd1;
            end
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_DELAY: begin
          if (cnt_r == 8'd0) begin
            state_nxt_s = ST_OVERRIDE;
            cnt_nxt_s   = duration_r - 8'd1;
            fire_s      = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r - 8'd1;
          end
        end
        ST_OVERRIDE: begin
          // DURATION=0 means hold until disabled; registers are frozen outside IDLE.
          if (duration_r == 8'd0) begin
            state_nxt_s = ST_OVERRIDE;
          end else if (cnt_r == 8'd0) begin
            state_nxt_s = oneshot_r ? ST_DONE : ST_ARMED;
            cnt_nxt_s   = 8'd0;
          end else begin
            cnt_nxt_s = cnt_r - 8'd1;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end
      endcase
    end
  end

  // Configuration registers and hit counter; a clear write beats an increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_r     <= 1'b0;
      oneshot_r    <= 1'b0;
      match_val_r  <= {OBS_W{1'b0}};
      match_mask_r <= {OBS_W{1'b0}};
      delay_r      <= 8'd0;
      duration_r   <= 8'd0;
      ovr_val_r    <= {CTL_W{1'b0}};
      ovr_mask_r   <= {CTL_W{1'b0}};
      hit_cnt_r    <= 8'd0;
    end else begin
      if (ctrl_wr_s) begin
        enable_r  <= cfg_wdata[0];
        oneshot_r <= cfg_wdata[1];
      end
      if (cfg_we && (state_r == ST_IDLE)) begin
        case (cfg_addr)
          3'd1:    match_val_r  <= cfg_wdata[OBS_W-1:0];
          3'd2:    match_mask_r <= cfg_wdata[OBS_W-1:0];
          3'd3:    delay_r      <= cfg_wdata;
          3'd4:    duration_r   <= cfg_wdata;
          3'd5:    ovr_val_r    <= cfg_wdata[CTL_W-1:0];
          3'd6:    ovr_mask_r   <= cfg_wdata[CTL_W-1:0];
          default: begin end
        endcase
      end
      if (hit_clr_s) begin
        hit_cnt_r <= 8'd0;
      end else if (fire_s && (hit_cnt_r != 8'hFF)) begin
        hit_cnt_r <= hit_cnt_r + 8'd1;
      end
    end
  end

  // Status decode and the override mux on the controlled signal.
  always_comb begin
    active_s     = (state_r == ST_OVERRIDE);
    patch_active = active_s;
    patch_done   = (state_r == ST_DONE);
    if (active_s) begin
      ctrl_out = (ctrl_in & ~ovr_mask_r) | (ovr_val_r & ovr_mask_r);
    end else begin
      ctrl_out = ctrl_in;
    end
  end

  // Register readback; unused upper bits read as zero.
  always_comb begin
    cfg_rdata = 8'd0;
    case (cfg_addr)
      3'd0:    cfg_rdata[1:0]       = {oneshot_r, enable_r};
      3'd1:    cfg_rdata[OBS_W-1:0] = match_val_r;
      3'd2:    cfg_rdata[OBS_W-1:0] = match_mask_r;
      3'd3:    cfg_rdata            = delay_r;
      3'd4:    cfg_rdata            = duration_r;
      3'd5:    cfg_rdata[CTL_W-1:0] = ovr_val_r;
      3'd6:    cfg_rdata[CTL_W-1:0] = ovr_mask_r;
      3'd7:    cfg_rdata            = hit_cnt_r;
      default: cfg_rdata            = 8'd0;
    endcase
  end

endmodule

// File: tb/tb_patch_trigger_ctrl.sv
// Testbench for patch_trigger_ctrl: a table of directed cycles, hand-written
// corner sequences, then random episodes checked against a timeline model.
module tb_patch_trigger_ctrl;
  localparam int OBS_W = 1;
  localparam int CTL_W = 2;
  localparam int BIG   = 32'h3fff_ffff;

  typedef logic [OBS_W-1:0] obs_t;
  typedef logic [CTL_W-1:0] ctl_t;

  logic       clk, rst;
  obs_t       observe_in;
  ctl_t       ctrl_in, ctrl_out;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata, cfg_rdata;
  logic       patch_active, patch_done;

  int n_vec = 0;
  int n_bad = 0;

  patch_trigger_ctrl #(.OBS_W(OBS_W), .CTL_W(CTL_W)) dut (
    .clk(clk), .rst(rst), .observe_in(observe_in), .ctrl_in(ctrl_in),
    .ctrl_out(ctrl_out), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .patch_active(patch_active), .patch_done(patch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wd;
    obs_t       obs;
    ctl_t       ctl;
    ctl_t       eo;
    logic       ea;
    logic       ed;
    logic [7:0] er;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                              input obs_t obs, input ctl_t ctl, input ctl_t eo,
                              input logic ea, input logic ed, input logic [7:0] er);
    vec_t v;
    v.we = we; v.addr = addr; v.wd = wd; v.obs = obs; v.ctl = ctl;
    v.eo = eo; v.ea = ea; v.ed = ed; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input ctl_t eo, input logic ea, input logic ed,
                         input logic [7:0] er);
    chk({nm, ".ctrl_out"}, 32'(ctrl_out), 32'(eo));
    chk({nm, ".active"}, 32'(patch_active), 32'(ea));
    chk({nm, ".done"}, 32'(patch_done), 32'(ed));
    chk({nm, ".rdata"}, 32'(cfg_rdata), 32'(er));
  endtask

  // One clock cycle: drive inputs after the falling edge, settle, return.
  task automatic go(input logic r, input obs_t o, input ctl_t c, input logic w,
                    input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    rst = r; observe_in = o; ctrl_in = c; cfg_we = w; cfg_addr = a; cfg_wdata = d;
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    go(1'b0, obs_t'(0), ctl_t'(1), 1'b1, a, d);
  endtask

  // ---------------- timeline reference model for random episodes ----------
  // An episode is described by when matching is accepted (arm), and the
  // cycle window [start,end] of the scheduled override.
  int cyc;
  int m_en, m_one, m_mval, m_mmask, m_delay, m_dur, m_oval, m_omask, m_hit;
  int m_arm, m_start, m_end, m_clr_prev;

  task automatic model_reset();
    m_en = 0; m_one = 0; m_mval = 0; m_mmask = 0; m_delay = 0; m_dur = 0;
    m_oval = 0; m_omask = 0; m_hit = 0; m_arm = -1; m_start = -1; m_end = -1;
    m_clr_prev = 0;
  endtask

  task automatic rcycle(input logic r, input obs_t o, input ctl_t c, input logic w,
                        input logic [2:0] a, input logic [7:0] d);
    int act, done, eo, er, cm, om;
    go(r, o, c, w, a, d);
    cm = (1 << CTL_W) - 1;
    om = (1 << OBS_W) - 1;
    if (m_en != 0 && cyc == m_start && m_clr_prev == 0)
      m_hit = (m_hit >= 255) ? 255 : m_hit + 1;
    act  = (m_en != 0 && m_start >= 0 && cyc >= m_start && cyc <= m_end) ? 1 : 0;
    done = (m_en != 0 && m_one != 0 && m_start >= 0 && cyc > m_end) ? 1 : 0;
    eo   = act ? (((int'(c) & ~m_omask) | (m_oval & m_omask)) & cm) : int'(c);
    case (a)
      3'd0: er = m_one * 2 + m_en;
      3'd1: er = m_mval;
      3'd2: er = m_mmask;
      3'd3: er = m_delay;
      3'd4: er = m_dur;
      3'd5: er = m_oval;
      3'd6: er = m_omask;
      default: er = m_hit;
    endcase
    chk("rnd.ctrl_out", 32'(ctrl_out), 32'(eo));
    chk("rnd.active", 32'(patch_active), 32'(act));
    chk("rnd.done", 32'(patch_done), 32'(done));
    chk("rnd.rdata", 32'(cfg_rdata), 32'(er));
    m_clr_prev = 0;
    if (r) begin
      model_reset();
    end else begin
      if (w && a == 3'd7) begin
        m_hit = 0;
        m_clr_prev = 1;
      end
      if (w && a >= 3'd1 && a <= 3'd6 && m_en == 0) begin
        case (a)
          3'd1: m_mval = int'(d) & om;
          3'd2: m_mmask = int'(d) & om;
          3'd3: m_delay = int'(d);
          3'd4: m_dur = int'(d);
          3'd5: m_oval = int'(d) & cm;
          default: m_omask = int'(d) & cm;
        endcase
      end
      if (w && a == 3'd0 && d[0] == 1'b0) begin
        m_en = 0; m_one = int'(d[1]); m_arm = -1; m_start = -1; m_end = -1;
      end else begin
        if (m_en != 0 && m_arm >= 0 && cyc >= m_arm &&
            ((int'(o) ^ m_mval) & m_mmask) == 0) begin
          m_start = cyc + 1 + m_delay;
          m_end   = (m_dur == 0) ? BIG : m_start + m_dur - 1;
          m_arm   = (m_one != 0 || m_dur == 0) ? -1 : m_end + 1;
        end
        if (w && a == 3'd0) begin
          if (m_en == 0) begin
            m_en = 1; m_arm = cyc + 1; m_start = -1; m_end = -1;
          end
          m_one = int'(d[1]);
        end
      end
    end
    cyc++;
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    int   found;

    rst = 1'b1; observe_in = '0; ctrl_in = 2'b01; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 8'd0;

    // Reset state: passthrough, no activity, every register reads 0.
    go(1'b1, obs_t'(0), 2'b01, 1'b0, 3'd0, 8'd0);
    go(1'b1, obs_t'(0), 2'b01, 1'b0, 3'd0, 8'd0);
    for (int a = 0; a < 8; a++) begin
      go(1'b0, obs_t'(0), 2'b01, 1'b0, 3'(a), 8'd0);
      chk_all("reset", 2'b01, 1'b0, 1'b0, 8'd0);
    end

    // Directed table: DELAY=0, DURATION=3, re-arm, exit-cycle match ignored, disable.
    //             we  addr  wd     obs   ctl    eo     ea    ed    er
    tbl.push_back(mk(1'b1, 3'd1, 8'h01, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 3'd2, 8'h01, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 3'd3, 8'h00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 3'd4, 8'h03, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 3'd5, 8'h00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 3'd6, 8'h03, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 3'd0, 8'h01, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b0, 3'd7, 8'h00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b0, 3'd0, 8'h00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 8'h01));
    tbl.push_back(mk(1'b0, 3'd7, 8'h00, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b0, 3'd7, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 8'h01));
    tbl.push_back(mk(1'b0, 3'd4, 8'h00, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 8'h03));
    tbl.push_back(mk(1'b0, 3'd7, 8'h00, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 8'h01));
    tbl.push_back(mk(1'b0, 3'd7, 8'h00, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 8'h01));
    tbl.push_back(mk(1'b0, 3'd6, 8'h00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 8'h03));
    tbl.push_back(mk(1'b0, 3'd1, 8'h00, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 8'h01));
    tbl.push_back(mk(1'b0, 3'd7, 8'h00, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 8'h02));
    tbl.push_back(mk(1'b1, 3'd0, 8'h00, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 8'h01));
    tbl.push_back(mk(1'b0, 3'd0, 8'h00, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b0, 3'd7, 8'h00, 1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 8'h02));
    foreach (tbl[i]) begin
      go(1'b0, tbl[i].obs, tbl[i].ctl, tbl[i].we, tbl[i].addr, tbl[i].wd);
      chk_all($sformatf("tbl[%0d]", i), tbl[i].eo, tbl[i].ea, tbl[i].ed, tbl[i].er);
    end

    // DELAY=4, DURATION=1, oneshot: single override at T+5, then DONE.
    wr(3'd3, 8'd4); wr(3'd4, 8'd1); wr(3'd7, 8'd0); wr(3'd0, 8'h03);
    go(1'b0, obs_t'(0), 2'b01, 1'b0, 3'd7, 8'd0);
    chk_all("os.armed", 2'b01, 1'b0, 1'b0, 8'd0);
    go(1'b0, obs_t'(1), 2'b01, 1'b0, 3'd7, 8'd0);
    chk_all("os.match", 2'b01, 1'b0, 1'b0, 8'd0);
    for (int k = 1; k <= 10; k++) begin
      go(1'b0, obs_t'(1), 2'b01, 1'b0, 3'd7, 8'd0);
      chk_all($sformatf("os.T+%0d", k), (k == 5) ? 2'b00 : 2'b01, k == 5, k >= 6,
              (k >= 5) ? 8'd1 : 8'd0);
    end
    wr(3'd0, 8'h00);

    // DURATION=0: override held until disabled.
    wr(3'd4, 8'd0); wr(3'd6, 8'h02); wr(3'd5, 8'h02); wr(3'd3, 8'd0); wr(3'd0, 8'h01);
    go(1'b0, obs_t'(0), 2'b01, 1'b0, 3'd7, 8'd0);
    go(1'b0, obs_t'(1), 2'b01, 1'b0, 3'd7, 8'd0);
    chk_all("hold.match", 2'b01, 1'b0, 1'b0, 8'd1);
    for (int k = 1; k <= 20; k++) begin
      go(1'b0, obs_t'(k & 1), 2'b01, 1'b0, 3'd7, 8'd0);
      chk_all("hold.ovr", 2'b11, 1'b1, 1'b0, 8'd2);
    end
    go(1'b0, obs_t'(0), 2'b01, 1'b1, 3'd0, 8'h00);
    chk_all("hold.dis_cycle", 2'b11, 1'b1, 1'b0, 8'h01);
    go(1'b0, obs_t'(0), 2'b01, 1'b0, 3'd0, 8'h00);
    chk_all("hold.after_dis", 2'b01, 1'b0, 1'b0, 8'h00);

    // Disable write in the same cycle as a match; writes ignored while armed.
    wr(3'd4, 8'd2); wr(3'd0, 8'h01);
    go(1'b0, obs_t'(0), 2'b01, 1'b0, 3'd7, 8'd0);
    chk_all("dm.armed", 2'b01, 1'b0, 1'b0, 8'd2);
    go(1'b0, obs_t'(1), 2'b01, 1'b1, 3'd0, 8'h00);
    chk_all("dm.dis_match", 2'b01, 1'b0, 1'b0, 8'h01);
    for (int k = 0; k < 4; k++) begin
      go(1'b0, obs_t'(1), 2'b10, 1'b0, (k == 0) ? 3'd0 : 3'd7, 8'd0);
      chk_all("dm.idle", 2'b10, 1'b0, 1'b0, (k == 0) ? 8'd0 : 8'd2);
    end
    wr(3'd0, 8'h01);
    go(1'b0, obs_t'(0), 2'b01, 1'b1, 3'd1, 8'h00);
    go(1'b0, obs_t'(0), 2'b01, 1'b0, 3'd1, 8'h00);
    chk_all("lock.mval", 2'b01, 1'b0, 1'b0, 8'h01);
    go(1'b0, obs_t'(0), 2'b01, 1'b0, 3'd1, 8'h00);
    chk_all("lock.nofire", 2'b01, 1'b0, 1'b0, 8'h01);
    wr(3'd0, 8'h00);

    // Saturation: MASK=0, DURATION=1 fires every other cycle.
    wr(3'd2, 8'd0); wr(3'd4, 8'd1); wr(3'd3, 8'd0); wr(3'd7, 8'd0); wr(3'd0, 8'h01);
    for (int k = 0; k < 520; k++) go(1'b0, obs_t'($urandom_range(0, 1)), 2'b01, 1'b0, 3'd7, 8'd0);
    chk("sat.hit", 32'(cfg_rdata), 32'd255);
    found = 0;
    for (int k = 0; k < 3 && found == 0; k++) begin
      go(1'b0, obs_t'(0), 2'b01, 1'b0, 3'd7, 8'd0);
      if (patch_active) found = 1;
    end
    chk("sat.find_ovr", 32'(found), 32'd1);
    for (int k = 0; k < 2; k++) begin
      go(1'b0, obs_t'(0), 2'b01, 1'b1, 3'd7, 8'd0);
      chk("clr.fire_cycle_active", 32'(patch_active), 32'd0);
      go(1'b0, obs_t'(0), 2'b01, 1'b0, 3'd7, 8'd0);
      chk("clr.active", 32'(patch_active), 32'd1);
      chk("clr.hit", 32'(cfg_rdata), 32'd0);
    end
    wr(3'd0, 8'h00);

    // Random episodes against the timeline model.
    go(1'b1, obs_t'(0), 2'b01, 1'b0, 3'd0, 8'd0);
    model_reset();
    cyc = 0;
    for (int ep = 0; ep < 40; ep++) begin
      int len;
      logic [7:0] v;
      for (int a = 1; a <= 6; a++) begin
        case (a)
          3: v = 8'($urandom_range(0, 5));
          4: v = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
          default: v = 8'($urandom);
        endcase
        rcycle(1'b0, obs_t'($urandom), ctl_t'($urandom), 1'b1, 3'(a), v);
      end
      if ($urandom_range(0, 4) == 0)
        rcycle(1'b0, obs_t'($urandom), ctl_t'($urandom), 1'b1, 3'd7, 8'($urandom));
      v = 8'($urandom);
      v[0] = 1'b1;
      rcycle(1'b0, obs_t'($urandom), ctl_t'($urandom), 1'b1, 3'd0, v);
      len = $urandom_range(20, 50);
      for (int k = 0; k < len; k++) begin
        logic w;
        w = ($urandom_range(0, 9) == 0);
        rcycle(1'b0, obs_t'($urandom), ctl_t'($urandom), w,
               w ? 3'($urandom_range(1, 7)) : 3'($urandom_range(0, 7)), 8'($urandom));
      end
      if ($urandom_range(0, 3) == 0) begin
        rcycle(1'b1, obs_t'($urandom), ctl_t'($urandom), 1'b0, 3'($urandom_range(0, 7)), 8'd0);
      end else begin
        v = 8'($urandom);
        v[0] = 1'b0;
        rcycle(1'b0, obs_t'($urandom), ctl_t'($urandom), 1'b1, 3'd0, v);
      end
      for (int k = 0; k < 2; k++)
        rcycle(1'b0, obs_t'($urandom), ctl_t'($urandom), 1'b0, 3'($urandom_range(0, 7)), 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/patch_trigger_ctrl.md
Name: patch_trigger_ctrl

Overview:
Programmable controller for one patch point on a datapath signal.
- Watches the point's observe bits and matches them against a programmed trigger value/mask.
- After a programmed delay, overrides selected bits of the controlled signal for a programmed duration.
- Sits between the patched block's control_port_in/control_port_out pair and the patch configuration bus.
- Re-arms or stops after firing, depending on mode.

Parameters:
OBS_W, 1, width of observe input (1..8)
CTL_W, 2, width of controlled signal (1..8)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
observe_in  input  OBS_W  observe bits from the patch point
ctrl_in  input  CTL_W  original signal value (from the block's control_port_in)
ctrl_out  output  CTL_W  value returned to the block's control_port_out
cfg_we  input  1  config write strobe
cfg_addr  input  3  config register address
cfg_wdata  input  8  config write data
cfg_rdata  output  8  config read data for cfg_addr
patch_active  output  1  high while override is applied
patch_done  output  1  high in DONE state

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; it is the only reset.
- Register map: all registers are 8 bits. Narrower fields use the LSBs; unused bits read 0.
  - 0 CTRL: bit0 enable, bit1 oneshot
  - 1 MATCH_VAL
  - 2 MATCH_MASK
  - 3 DELAY
  - 4 DURATION
  - 5 OVR_VAL
  - 6 OVR_MASK
  - 7 HIT_CNT (read-only; any write clears it to 0)
- cfg_rdata: combinational read of the register at cfg_addr.
- Writes to addresses 1-6 take effect only in IDLE; they are ignored in any other state.
- Reset (rst=1 at a clk edge):
  - all registers 0, state IDLE, counter 0
  - patch_active=0, patch_done=0
  - ctrl_out follows ctrl_in
- Match condition: ((observe_in ^ MATCH_VAL) & MATCH_MASK) == 0. MATCH_MASK=0 matches every cycle.
- ctrl_out = patch_active ? ((ctrl_in & ~OVR_MASK) | (OVR_VAL & OVR_MASK)) : ctrl_in.
  - Combinational mux; zero added latency.
  - patch_active is a registered state decode.
- FSM states: IDLE, ARMED, DELAY, OVERRIDE, DONE.
  - IDLE → ARMED: on the edge that writes CTRL.enable=1. Matching starts the following cycle.
  - ARMED, match in cycle T:
    - DELAY=0: → OVERRIDE; override visible at cycle T+1.
    - DELAY=D>0: → DELAY with counter=D-1; override visible at cycle T+1+D.
  - DELAY: counter decrements each cycle; at 0 → OVERRIDE.
  - OVERRIDE, on entry: counter=DURATION-1; HIT_CNT increments, saturating at 255.
    - DURATION=0: override holds until disabled.
    - Otherwise, when the counter reaches 0 at the end of the DURATION-th cycle: oneshot=1 → DONE, oneshot=0 → ARMED.
    - A match in the same cycle as the OVERRIDE→ARMED exit is not counted; matching resumes the cycle after the exit.
  - DONE: passthrough, patch_done=1. Holds until CTRL.enable is written 0.
  - CTRL write with enable=0, from any state: → IDLE next cycle, counter cleared. patch_active drops at the same edge.
- Simultaneous events:
  - Disable write wins over match or counter expiry.
  - HIT_CNT clear write wins over increment (result 0).
  - Writing CTRL with enable=1 while already enabled updates oneshot only; no state change.
- rst asserted mid-override: ctrl_out returns to passthrough on the same edge.

Test Plan:
- Reset, then ctrl_in=2'b01 → ctrl_out=2'b01; patch_active=0; cfg_rdata=0 at every address.
- MATCH_VAL=1, MASK=1, DELAY=0, DURATION=3, OVR_VAL=0, OVR_MASK=3, CTRL=1; observe_in=1 at cycle T → ctrl_out=0 for cycles T+1..T+3, passthrough at T+4; HIT_CNT=1; state re-arms.
- DELAY=4, DURATION=1, oneshot=1; match at T → single override cycle at T+5; then patch_done=1; further matches do not fire; HIT_CNT stays 1.
- DURATION=0, OVR_MASK=2'b10, OVR_VAL=2'b10, ctrl_in=2'b01 → ctrl_out=2'b11 held indefinitely. Write CTRL=0 → passthrough the cycle after the write.
- Write CTRL=0 in the same cycle as a match while ARMED → no override; state IDLE; HIT_CNT unchanged. Write MATCH_VAL while ARMED → readback unchanged.
- 256 fires with DURATION=1, MASK=0 → HIT_CNT saturates at 255. Write addr 7 in a fire cycle → HIT_CNT=0.
